// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the dmem port between the core and a DMA requester.
// Optional stall/wait statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner,
    output logic [31:0]   cpu_stall_cnt,
    output logic [31:0]   dma_wait_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CPU  = 2'b01,
        ST_DMA  = 2'b10
    } state_t;

    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_DMA = 1'b1;

    state_t          r_state;
    state_t          w_state_nxt;
    state_t          w_oth_state;
    logic            r_last_owner;
    logic            w_last_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic [4:0]      w_cnt_inc;
    logic            w_own_req;
    logic            w_own_we;
    logic            w_own_id;
    logic [AW-1:0]   w_own_addr;
    logic [DW-1:0]   w_own_wdata;
    logic            w_oth_req;
    logic            w_cpu_ack;

    // State register: owner, tie-break history and burst length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_owner <= LAST_DMA;
            r_cnt        <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Select the current owner's request and the waiting side's request.
    always_comb begin
        w_own_req   = 1'b0;
        w_own_we    = 1'b0;
        w_own_id    = LAST_CPU;
        w_own_addr  = '0;
        w_own_wdata = '0;
        w_oth_req   = 1'b0;
        w_oth_state = ST_IDLE;
        case (r_state)
            ST_CPU: begin
                w_own_req   = cpu_req;
                w_own_we    = cpu_we;
                w_own_id    = LAST_CPU;
                w_own_addr  = cpu_addr;
                w_own_wdata = cpu_wdata;
                w_oth_req   = dma_req;
                w_oth_state = ST_DMA;
            end
            ST_DMA: begin
                w_own_req   = dma_req;
                w_own_we    = dma_we;
                w_own_id    = LAST_DMA;
                w_own_addr  = dma_addr;
                w_own_wdata = dma_wdata;
                w_oth_req   = cpu_req;
                w_oth_state = ST_CPU;
            end
            default: begin
                w_own_req   = 1'b0;
                w_oth_state = ST_IDLE;
            end
        endcase
    end

    assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;

    // Next owner: round-robin from IDLE, bounded tenure while the other side waits.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_owner;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (cpu_req && dma_req) begin
                    w_state_nxt = (r_last_owner == LAST_DMA) ? ST_CPU : ST_DMA;
                end else if (cpu_req) begin
                    w_state_nxt = ST_CPU;
                end else if (dma_req) begin
                    w_state_nxt = ST_DMA;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CPU, ST_DMA: begin
                if (!w_own_req) begin
                    w_state_nxt = w_oth_req ? w_oth_state : ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_last_nxt  = w_own_id;
                // >= rather than == so a saturated tenure still yields once the other side asks
                end else if ((w_cnt_inc >= 5'(MAX_BURST)) && w_oth_req) begin
                    w_state_nxt = w_oth_state;
                    w_cnt_nxt   = 4'd0;
                    w_last_nxt  = w_own_id;
                end else if (w_cnt_inc > 5'(MAX_BURST)) begin
                    w_cnt_nxt = 4'(MAX_BURST);
                end else begin
                    w_cnt_nxt = w_cnt_inc[3:0];
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign mem_we    = w_own_req & w_own_we & ~reset;
    assign mem_addr  = w_own_addr;
    assign mem_wdata = w_own_wdata;
    assign w_cpu_ack = (r_state == ST_CPU) & cpu_req;
    assign dma_ack   = (r_state == ST_DMA) & dma_req;
    assign cpu_stall = cpu_req & ~w_cpu_ack;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;
    assign owner     = r_state;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_cpu_stall_cnt;
    logic [31:0] r_dma_wait_cnt;

    // Free-running stall and wait statistics; wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_stall_cnt <= 32'd0;
            r_dma_wait_cnt  <= 32'd0;
        end else begin
            if (cpu_stall) begin
                r_cpu_stall_cnt <= r_cpu_stall_cnt + 32'd1;
            end else begin
                r_cpu_stall_cnt <= r_cpu_stall_cnt;
            end
            if (dma_req && !dma_ack) begin
                r_dma_wait_cnt <= r_dma_wait_cnt + 32'd1;
            end else begin
                r_dma_wait_cnt <= r_dma_wait_cnt;
            end
        end
    end

    assign cpu_stall_cnt = r_cpu_stall_cnt;
    assign dma_wait_cnt  = r_dma_wait_cnt;
`else
    assign cpu_stall_cnt = 32'd0;
    assign dma_wait_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, dma_ack, mem_we;
    logic [1:0]  owner;
    logic [31:0] cpu_stall_cnt, dma_wait_cnt;
    logic [31:0] mem [0:255];
    int          n_checks;
    int          n_errors;

    dmem_arbiter #(.MAX_BURST(4), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .cpu_stall_cnt(cpu_stall_cnt), .dma_wait_cnt(dma_wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        #1;
        check_eq("rst_owner", {30'd0, owner}, 32'd0);
        next_cycle();
        reset = 1'b0;
    endtask

    logic [1:0] exp_rr [0:12];

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h20] = 32'hCAFEF00D;
        exp_rr = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        check_eq("rst_owner0", {30'd0, owner}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check_eq("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_stall_cnt", cpu_stall_cnt, 32'd0);
        check_eq("rst_wait_cnt", dma_wait_cnt, 32'd0);
        next_cycle();
        reset = 1'b0;

        // CPU alone: write 0x40 then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF;
        #1;
        check_eq("cpu_c0_stall", {31'd0, cpu_stall}, 32'd1);
        check_eq("cpu_c0_owner", {30'd0, owner}, 32'd0);
        check_eq("cpu_c0_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        check_eq("cpu_c1_owner", {30'd0, owner}, 32'd1);
        check_eq("cpu_c1_we", {31'd0, mem_we}, 32'd1);
        check_eq("cpu_c1_stall", {31'd0, cpu_stall}, 32'd0);
        check_eq("cpu_c1_addr", mem_addr, 32'h40);
        check_eq("cpu_c1_wdata", mem_wdata, 32'hDEADBEEF);
        next_cycle();
        cpu_we = 1'b0;
        #1;
        check_eq("cpu_rd_stall", {31'd0, cpu_stall}, 32'd0);
        check_eq("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        check_eq("cpu_rd_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        cpu_req = 1'b0;
        #1;
        check_eq("cpu_drop_owner", {30'd0, owner}, 32'd1);
        check_eq("cpu_drop_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        check_eq("cpu_idle_owner", {30'd0, owner}, 32'd0);

        // Both requesting from reset: 4 CPU, direct handover, 4 DMA, repeat
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h40; dma_req = 1'b1; dma_addr = 32'h80;
        for (int k = 0; k < 13; k++) begin
            #1;
            check_eq($sformatf("rr_owner_%0d", k), {30'd0, owner}, {30'd0, exp_rr[k]});
            check_eq($sformatf("rr_stall_%0d", k), {31'd0, cpu_stall}, {31'd0, exp_rr[k] != 2'd1});
            check_eq($sformatf("rr_dack_%0d", k), {31'd0, dma_ack}, {31'd0, exp_rr[k] == 2'd2});
            next_cycle();
        end

        // DMA drops after 2 accesses while CPU waits; CPU tenure restarts at full length
        do_reset();
        dma_req = 1'b1; dma_addr = 32'h80;
        #1;
        check_eq("drop_k0_owner", {30'd0, owner}, 32'd0);
        next_cycle();
        check_eq("drop_k1_owner", {30'd0, owner}, 32'd2);
        check_eq("drop_k1_ack", {31'd0, dma_ack}, 32'd1);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h40;
        #1;
        check_eq("drop_k2_ack", {31'd0, dma_ack}, 32'd1);
        check_eq("drop_k2_stall", {31'd0, cpu_stall}, 32'd1);
        next_cycle();
        dma_req = 1'b0;
        #1;
        check_eq("drop_k3_owner", {30'd0, owner}, 32'd2);
        check_eq("drop_k3_ack", {31'd0, dma_ack}, 32'd0);
        check_eq("drop_k3_stall", {31'd0, cpu_stall}, 32'd1);
        next_cycle();
        dma_req = 1'b1;
        for (int k = 4; k < 9; k++) begin
            #1;
            check_eq($sformatf("drop_k%0d_owner", k), {30'd0, owner}, (k < 8) ? 32'd1 : 32'd2);
            next_cycle();
        end

        // DMA write to 0x80 aborted by a mid-cycle async reset
        do_reset();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h12345678;
        next_cycle();
        check_eq("abort_we_before", {31'd0, mem_we}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort_we_after", {31'd0, mem_we}, 32'd0);
        check_eq("abort_owner", {30'd0, owner}, 32'd0);
        check_eq("abort_ack", {31'd0, dma_ack}, 32'd0);
        next_cycle();
        reset = 1'b0;
        dma_we = 1'b0;
        next_cycle();
        #1;
        check_eq("abort_rd_ack", {31'd0, dma_ack}, 32'd1);
        check_eq("abort_rd_data", dma_rdata, 32'hCAFEF00D);
        next_cycle();

        // Statistics: one CPU access, then DMA wins a tie and bursts 4 while the CPU waits
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h40;
        next_cycle();
        next_cycle();
        cpu_req = 1'b0;
        next_cycle();
        check_eq("st_idle_owner", {30'd0, owner}, 32'd0);
`ifdef DMEM_ARB_STATS_EN
        check_eq("st_stall_cnt1", cpu_stall_cnt, 32'd1);
`else
        check_eq("st_stall_cnt1", cpu_stall_cnt, 32'd0);
`endif
        cpu_req = 1'b1; dma_req = 1'b1; dma_addr = 32'h80;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq($sformatf("st_owner_%0d", k), {30'd0, owner},
                     (k == 0) ? 32'd0 : ((k < 5) ? 32'd2 : 32'd1));
            if (k < 5) next_cycle();
        end
`ifdef DMEM_ARB_STATS_EN
        check_eq("st_stall_cnt", cpu_stall_cnt, 32'd6);
        check_eq("st_wait_cnt", dma_wait_cnt, 32'd1);
`else
        check_eq("st_stall_cnt", cpu_stall_cnt, 32'd0);
        check_eq("st_wait_cnt", dma_wait_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
